// File: rtl/spi_slave_param_if.sv
// rtl/spi_slave_param_if.sv - SPI pin and RAM-side signal bundle for spi_slave_param
interface spi_slave_param_if #(
  parameter int PAYLOAD_W = 8
);
  localparam int FRAME_W = PAYLOAD_W + 2;

  logic                 SS_n;
  logic                 MOSI;
  logic                 tx_valid;
  logic [PAYLOAD_W-1:0] tx_data;
  logic                 MISO;
  logic [FRAME_W-1:0]   rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  SS_n, MOSI, tx_valid, tx_data,
    output MISO, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output SS_n, MOSI, tx_valid, tx_data,
    input  MISO, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - SPI slave front-end: frame deserialiser, RAM read-data serialiser
module spi_slave_param #(
  parameter int PAYLOAD_W = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_param_if.slave bus
);
  localparam int FRAME_W = PAYLOAD_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TX_DONE = CNT_W'(PAYLOAD_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX      = 3'd1,
    WAIT_SS = 3'd2,
    TX_WAIT = 3'd3,
    TX      = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-2:0]   rx_sh_q, rx_sh_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic [PAYLOAD_W-1:0] tx_sh_q, tx_sh_d;
  logic                 miso_q, miso_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rd_pending_q, rd_pending_d;

  logic [FRAME_W-1:0]   rx_frame;
  logic [FRAME_W-2:0]   rx_shifted;
  logic [1:0]           rx_cmd;
  logic                 tx_load_bit;
  logic                 tx_cur_bit;
  logic [PAYLOAD_W-1:0] tx_load_sh;
  logic [PAYLOAD_W-1:0] tx_next_sh;

  // The frame as it would stand if the current MOSI bit were its last one.
  always_comb begin
    rx_frame    = LSB_FIRST ? {bus.MOSI, rx_sh_q} : {rx_sh_q, bus.MOSI};
    rx_shifted  = LSB_FIRST ? rx_frame[FRAME_W-1:1] : rx_frame[FRAME_W-2:0];
    rx_cmd      = rx_frame[FRAME_W-1 -: 2];
    tx_load_bit = LSB_FIRST ? bus.tx_data[0] : bus.tx_data[PAYLOAD_W-1];
    tx_cur_bit  = LSB_FIRST ? tx_sh_q[0] : tx_sh_q[PAYLOAD_W-1];
    tx_load_sh  = LSB_FIRST ? (bus.tx_data >> 1) : (bus.tx_data << 1);
    tx_next_sh  = LSB_FIRST ? (tx_sh_q >> 1) : (tx_sh_q << 1);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_sh_d      = rx_sh_q;
    rx_data_d    = rx_data_q;
    tx_sh_d      = tx_sh_q;
    miso_d       = 1'b0;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    rd_pending_d = rd_pending_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus.SS_n) begin
          rx_sh_d = rx_shifted;
          cnt_d   = CNT_ONE;
          state_d = RX;
        end
      end

      RX: begin
        if (bus.SS_n) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_q == RX_LAST) begin
          rx_sh_d    = rx_shifted;
          rx_data_d  = rx_frame;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_SS;
          case (rx_cmd)
            2'b10: rd_pending_d = 1'b1;
            2'b11: begin
              if (rd_pending_q) begin
                state_d = TX_WAIT;
              end else begin
                frame_err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end else begin
          rx_sh_d = rx_shifted;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      WAIT_SS: begin
        cnt_d = '0;
        if (bus.SS_n) begin
          state_d = IDLE;
        end
      end

      TX_WAIT: begin
        if (bus.SS_n) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (bus.tx_valid) begin
          tx_sh_d = tx_load_sh;
          miso_d  = tx_load_bit;
          cnt_d   = CNT_ONE;
          state_d = TX;
        end
      end

      TX: begin
        // An abort here keeps rd_pending so the host can retry the read-data frame.
        if (bus.SS_n) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_q == TX_DONE) begin
          rd_pending_d = 1'b0;
          cnt_d        = '0;
          state_d      = WAIT_SS;
        end else begin
          miso_d  = tx_cur_bit;
          tx_sh_d = tx_next_sh;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rx_sh_q      <= '0;
      rx_data_q    <= '0;
      tx_sh_q      <= '0;
      miso_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_sh_q      <= rx_sh_d;
      rx_data_q    <= rx_data_d;
      tx_sh_q      <= tx_sh_d;
      miso_q       <= miso_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign bus.MISO      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - scoreboard bench for spi_slave_param, MSB-first and LSB-first builds
module tb_spi_slave_param;
  localparam int PW = 8;
  localparam int FW = PW + 2;

  typedef struct {
    int            cyc;
    logic          vld;
    logic          err;
    logic [FW-1:0] data;
  } ev_t;

  typedef struct {
    int            start;
    int            len;
    logic [PW-1:0] word;
  } txr_t;

  logic clk;
  logic rst_n;
  logic ss_n, mosi, txv;
  logic [PW-1:0] txd;
  bit   sel;
  int   cyc = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  ev_t  ev_q[$];
  txr_t tx_q[$];
  bit            pend[2];
  logic [FW-1:0] last_rx[2];

  spi_slave_param_if #(.PAYLOAD_W(PW)) bus_m ();
  spi_slave_param_if #(.PAYLOAD_W(PW)) bus_l ();

  assign bus_m.SS_n     = sel ? 1'b1 : ss_n;
  assign bus_m.MOSI     = mosi;
  assign bus_m.tx_valid = txv;
  assign bus_m.tx_data  = txd;
  assign bus_l.SS_n     = sel ? ss_n : 1'b1;
  assign bus_l.MOSI     = mosi;
  assign bus_l.tx_valid = txv;
  assign bus_l.tx_data  = txd;

  spi_slave_param #(.PAYLOAD_W(PW), .LSB_FIRST(1'b0)) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  spi_slave_param #(.PAYLOAD_W(PW), .LSB_FIRST(1'b1)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  logic          o_miso, o_rxv, o_err, o_busy;
  logic [FW-1:0] o_rxd;
  assign o_miso = sel ? bus_l.MISO      : bus_m.MISO;
  assign o_rxv  = sel ? bus_l.rx_valid  : bus_m.rx_valid;
  assign o_err  = sel ? bus_l.frame_err : bus_m.frame_err;
  assign o_busy = sel ? bus_l.busy      : bus_m.busy;
  assign o_rxd  = sel ? bus_l.rx_data   : bus_m.rx_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic v, input logic e, input logic [FW-1:0] d);
    ev_t x;
    x.cyc = c; x.vld = v; x.err = e; x.data = d;
    ev_q.push_back(x);
  endtask

  task automatic push_tx(input int s, input int l, input logic [PW-1:0] w);
    txr_t x;
    x.start = s; x.len = l; x.word = w;
    tx_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    txv = 1'($urandom_range(0, 1));
    txd = PW'($urandom);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      ss_n = 1'b1; mosi = 1'($urandom); noise();
      step();
    end
  endtask

  // SS_n still low after a finished frame: MOSI and tx_valid must both be ignored.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      ss_n = 1'b0; mosi = 1'($urandom); txv = 1'b1; txd = PW'($urandom);
      step();
    end
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input int nbits, output bit to_tx);
    to_tx = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      ss_n = 1'b0;
      mosi = sel ? f[i] : f[FW-1-i];
      noise();
      if (i == FW - 1) begin
        if (f[FW-1:FW-2] == 2'b11) begin
          push_ev(cyc + 1, 1'b1, !pend[sel], f);
          to_tx = pend[sel];
        end else begin
          push_ev(cyc + 1, 1'b1, 1'b0, f);
          if (f[FW-1:FW-2] == 2'b10) pend[sel] = 1'b1;
        end
        last_rx[sel] = f;
      end
      step();
      if (i == 0) check("busy_in_frame", 32'(o_busy), 32'd1);
    end
    if (nbits < FW) begin
      ss_n = 1'b1; noise();
      push_ev(cyc + 1, 1'b0, 1'b1, last_rx[sel]);
      step();
      check("busy_after_abort", 32'(o_busy), 32'd0);
    end
  endtask

  // abort_at: -1 none, 0 abort while waiting for tx_valid, j>0 abort j edges after the load edge.
  task automatic tx_phase(input logic [PW-1:0] w, input int delay, input int abort_at,
                          input bit rst3, output bit done);
    int l;
    done = 1'b0;
    for (int i = 1; i < delay; i++) begin
      ss_n = 1'b0; mosi = 1'($urandom); txv = 1'b0; txd = PW'($urandom);
      step();
    end
    if (abort_at == 0) begin
      ss_n = 1'b1; noise();
      push_ev(cyc + 1, 1'b0, 1'b1, last_rx[sel]);
      step();
      return;
    end
    l = cyc + 1;
    push_tx(l, (abort_at > 0) ? abort_at : (rst3 ? 3 : PW), w);
    ss_n = 1'b0; txv = 1'b1; txd = w; mosi = 1'($urandom);
    step();
    for (int j = 1; j <= PW; j++) begin
      if (abort_at == j) begin
        ss_n = 1'b1; noise();
        push_ev(cyc + 1, 1'b0, 1'b1, last_rx[sel]);
        step();
        return;
      end
      if (rst3 && j == 3) begin
        rst_n = 1'b0; ss_n = 1'b1; noise();
        step();
        check("rst_mid_tx_outputs", {o_miso, o_rxv, o_err, o_busy, 22'(o_rxd)}, 32'd0);
        rst_n = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        last_rx[0] = '0; last_rx[1] = '0;
        return;
      end
      ss_n = 1'b0; mosi = 1'($urandom); noise();
      step();
    end
    pend[sel] = 1'b0;
    done = 1'b1;
  endtask

  logic exp_m;
  int   mk;
  always @(negedge clk) begin
    if (cyc > 0) begin
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        vec_cnt++; err_cnt++;
        $display("FAIL missing_pulse: expected vld=%0b err=%0b at cycle %0d, not observed",
                 ev_q[0].vld, ev_q[0].err, ev_q[0].cyc);
        ev_q.delete(0);
      end
      if (o_rxv || o_err) begin
        vec_cnt++;
        if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
          err_cnt++;
          $display("FAIL unexpected_pulse: got vld=%0b err=%0b data=%0h at cycle %0d, expected none",
                   o_rxv, o_err, o_rxd, cyc);
        end else begin
          if (o_rxv !== ev_q[0].vld || o_err !== ev_q[0].err || o_rxd !== ev_q[0].data) begin
            err_cnt++;
            $display("FAIL pulse: got vld=%0b err=%0b data=%0h, expected vld=%0b err=%0b data=%0h (cycle %0d)",
                     o_rxv, o_err, o_rxd, ev_q[0].vld, ev_q[0].err, ev_q[0].data, cyc);
          end
          ev_q.delete(0);
        end
      end
      while (tx_q.size() > 0 && cyc >= tx_q[0].start + tx_q[0].len) tx_q.delete(0);
      exp_m = 1'b0;
      if (tx_q.size() > 0 && cyc >= tx_q[0].start) begin
        mk    = cyc - tx_q[0].start;
        exp_m = sel ? tx_q[0].word[mk] : tx_q[0].word[PW-1-mk];
      end
      vec_cnt++;
      if (o_miso !== exp_m) begin
        err_cnt++;
        $display("FAIL miso: got %0b, expected %0b (cycle %0d)", o_miso, exp_m, cyc);
      end
    end
  end

  bit to_tx, done, ab;
  logic [FW-1:0] f;
  int r;
  initial begin
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; txv = 1'b0; txd = '0; sel = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0; last_rx[0] = '0; last_rx[1] = '0;
    step(); step(); step();
    check("reset_outputs", {o_miso, o_rxv, o_err, o_busy, 22'(o_rxd)}, 32'd0);
    rst_n = 1'b1;
    gap(2);

    send_frame(10'h0A5, FW, to_tx); hold(2); gap(1);
    send_frame(10'h203, FW, to_tx); gap(1);
    send_frame(10'h35A, FW, to_tx);
    check("read_data_legal", 32'(to_tx), 32'd1);
    tx_phase(8'hC3, 2, -1, 1'b0, done); hold(1); gap(1);
    send_frame(10'h300, FW, to_tx); hold(3); gap(1);
    send_frame(10'h2E7, 5, to_tx); gap(1);
    send_frame(10'h1F0, FW, to_tx); gap(1);
    send_frame(10'h211, FW, to_tx); gap(1);
    send_frame(10'h3FF, FW, to_tx);
    tx_phase(8'h96, 1, -1, 1'b1, done); gap(1);
    send_frame(10'h3AA, FW, to_tx); gap(2);

    sel = 1'b1;
    gap(1);
    send_frame(10'h005, FW, to_tx); gap(1);
    send_frame(10'h280, FW, to_tx); gap(1);
    send_frame(10'h3C4, FW, to_tx);
    tx_phase(8'h01, 2, -1, 1'b0, done); gap(2);

    for (int n = 0; n < 300; n++) begin
      sel = (n >= 150);
      f   = FW'($urandom);
      ab  = ($urandom_range(0, 5) == 0);
      if (ab) begin
        send_frame(f, $urandom_range(1, FW - 1), to_tx);
        gap($urandom_range(0, 2));
      end else begin
        send_frame(f, FW, to_tx);
        if (to_tx) begin
          r = $urandom_range(0, 7);
          tx_phase(PW'($urandom), $urandom_range(1, 3),
                   (r == 0) ? 0 : ((r == 1) ? $urandom_range(1, PW - 1) : -1), 1'b0, done);
          if (done) hold($urandom_range(0, 2));
        end else begin
          hold($urandom_range(0, 2));
        end
        gap($urandom_range(1, 3));
      end
    end

    gap(4);
    check("events_drained", 32'(ev_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
